rvv_insn_queue: RTL
===================

// Module: rvv_insn_queue
// PURPOSE
//  Parametrised instruction queue between the host issue port and rvv_proc_main.
//  Buffers up to DEPTH instructions and applies ready/valid backpressure to the host.
//  Releases instructions to the core only while the core asserts proc_rdy.
//  Adds flush, occupancy reporting and an optional zero-latency bypass mode.
// PARAMETERS
//  INSN_WIDTH  32  width of one instruction word
//  DEPTH       4   queue entries; power of two, >= 2
//  BYPASS      0   1: an empty queue forwards insn_in to insn_out in the same cycle
//  CNT_W       $clog2(DEPTH)+1  occupancy width (derived, not overridden)
// PORTS
//  clk            in   1           clock
//  rst_n          in   1           asynchronous active-low reset
//  insn_in        in   INSN_WIDTH  instruction from host
//  insn_valid     in   1           host instruction valid
//  insn_ready     out  1           queue accepts insn_in this cycle
//  flush          in   1           synchronous discard of all queued instructions
//  insn_out       out  INSN_WIDTH  instruction to core
//  insn_valid_out out  1           insn_out valid
//  proc_rdy       in   1           core accepts insn_out this cycle
//  count          out  CNT_W       current occupancy (0..DEPTH)
//  full           out  1           count == DEPTH
//  empty          out  1           count == 0
// BEHAVIOUR
//  - Reset (rst_n=0, async): pointers=0, count=0, empty=1, full=0, insn_valid_out=0, insn_ready=1.
//    insn_out is don't-care while invalid; a reset mid-stream drops all entries.
//  - push = insn_valid & insn_ready; pop = insn_valid_out & proc_rdy.
//  - insn_ready = !full & !flush. No pass-through when full: a pop while full does not
//    enable a push in the same cycle.
//  - BYPASS=0: insn_out is the head entry; the first push into an empty queue gives
//    insn_valid_out=1 on the next cycle (1-cycle latency).
//    insn_valid_out = !empty.
//  - BYPASS=1, when empty & insn_valid & proc_rdy & !flush:
//    - insn_out = insn_in and insn_valid_out=1 combinationally;
//    - the instruction is consumed and not stored; count stays 0.
//    When empty & insn_valid & !proc_rdy, the instruction is stored normally.
//    When not empty, behaviour is as for BYPASS=0 (order is preserved).
//  - Simultaneous push and pop (not full, not bypassed): count unchanged; both pointers advance.
//  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH; count disambiguates full from empty.
//  - flush has priority over push and pop:
//    - next cycle: count=0, pointers=0;
//    - in the flush cycle: insn_valid_out=0 and insn_ready=0;
//    - the core never sees an instruction presented in a flush cycle.
//  - insn_out and insn_valid_out are held stable while insn_valid_out=1 & !proc_rdy.
//  - count, full and empty are registered (except the BYPASS path, which never changes them).
// STRUCTURE
//  - Shared package rvv_proc_pkg:
//    - INSN_WIDTH default;
//    - typedef insn_t = logic [INSN_WIDTH-1:0];
//    - function for clog2-based count width; reused by the mem-port queues.
//  - Sub-module rvv_sync_fifo(WIDTH, DEPTH): storage array, wrap pointers, count.
//  - rvv_insn_queue adds the ready/valid gating, flush priority and BYPASS mux.
//  - rvv_proc_wrapper instantiates rvv_insn_queue in front of rvv_proc_main.
// TESTING
//  1 Reset/fill: DEPTH=4, proc_rdy=0, push A1..A4 on 4 cycles
//    -> count 1,2,3,4; full=1; insn_ready=0; 5th valid word is not accepted.
//  2 Drain order: after test 1, set proc_rdy=1
//    -> insn_out A1,A2,A3,A4 on 4 consecutive cycles; then empty=1, insn_valid_out=0.
//  3 Wrap plus simultaneous push/pop: 10 cycles with push and pop every cycle at count=2
//    -> count stays 2; output sequence matches input order across pointer wrap.
//  4 Flush: count=3, assert flush with insn_valid=1
//    -> that word is dropped; next cycle count=0, insn_valid_out=0; next push appears 1 cycle later.
//  5 BYPASS=1: empty, proc_rdy=1, insn_in=0x00C58557
//    -> same cycle insn_out=0x00C58557 with valid=1; count stays 0.
//    With proc_rdy=0 -> the word is stored and count=1.
//  6 Async reset mid-stream: count=3, rst_n low mid-cycle
//    -> insn_valid_out=0 and count=0 immediately; after release, the first push is seen 1 cycle later.

Source files
------------

// File: rtl/rvv_proc_pkg.sv
// Shared definitions for the RVV processor front end: instruction word type and
// the occupancy-width helper used by every queue in the core.
package rvv_proc_pkg;

  localparam int DEF_INSN_WIDTH = 32;

  typedef logic [DEF_INSN_WIDTH-1:0] insn_t;

  // Occupancy must represent 0..depth inclusive, hence one bit more than the pointer.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rvv_sync_fifo.sv
// Synchronous FIFO storage: entry array, wrapping read/write pointers and an
// occupancy counter that tells full apart from empty. Callers guarantee no
// push while full and no pop while empty.
module rvv_sync_fifo
  import rvv_proc_pkg::*;
#(
  parameter int  WIDTH = DEF_INSN_WIDTH,
  parameter int  DEPTH = 4,
  localparam int CNT_W = cnt_width(DEPTH),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the data array is deliberately not reset; count gates every read of it.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr_q] <= wdata;
  end

  assign rdata = mem[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/rvv_insn_queue.sv
// Instruction queue between the host issue port and the vector core: ready/valid
// gating, flush priority and an optional zero-latency bypass around the FIFO.
module rvv_insn_queue
  import rvv_proc_pkg::*;
#(
  parameter int  INSN_WIDTH = DEF_INSN_WIDTH,
  parameter int  DEPTH      = 4,
  parameter bit  BYPASS     = 1'b0,
  localparam int CNT_W      = cnt_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INSN_WIDTH-1:0] insn_in,
  input  logic                  insn_valid,
  output logic                  insn_ready,
  input  logic                  flush,
  output logic [INSN_WIDTH-1:0] insn_out,
  output logic                  insn_valid_out,
  input  logic                  proc_rdy,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty
);

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [INSN_WIDTH-1:0] fifo_rdata;
  logic                  bypass_hit;

  rvv_sync_fifo #(
    .WIDTH (INSN_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .clear (flush),
    .wdata (insn_in),
    .rdata (fifo_rdata),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    // Bypass only when nothing is queued ahead, so program order is preserved.
    bypass_hit     = BYPASS && fifo_empty && insn_valid && proc_rdy && !flush;
    // Ready depends on full alone: a pop while full never frees a slot this cycle.
    insn_ready     = !fifo_full && !flush;
    insn_valid_out = !flush && (!fifo_empty || bypass_hit);
    insn_out       = (BYPASS && fifo_empty) ? insn_in : fifo_rdata;
    fifo_push      = insn_valid && insn_ready && !bypass_hit;
    fifo_pop       = !fifo_empty && proc_rdy && !flush;
  end

  assign full  = fifo_full;
  assign empty = fifo_empty;

endmodule
